// File: rtl/bcd_to_decimal_decoder_if.sv
// Handshake bundle for the BCD decoder: input digit stream and decoded output stream.
// The producer/consumer side uses master; the decoder uses slave.
interface bcd_to_decimal_decoder_if #(
    parameter int unsigned ERR_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       bcd;
    logic             out_valid;
    logic             out_ready;
    logic [9:0]       dec;
    logic             out_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, bcd, out_ready,
        input  in_ready, out_valid, dec, out_err, err_count
    );

    modport slave (
        input  in_valid, bcd, out_ready,
        output in_ready, out_valid, dec, out_err, err_count
    );
endinterface

// File: rtl/bcd_to_decimal_decoder.sv
// BCD to one-hot decimal decoder with a 2-entry output FIFO and a saturating
// counter of accepted invalid codes (1010-1111).
module bcd_to_decimal_decoder #(
    parameter int unsigned ERR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    bcd_to_decimal_decoder_if.slave bus
);
    localparam int unsigned DEPTH = 2;
    localparam int unsigned DEC_W = 10;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef struct packed {
        logic             err;
        logic [DEC_W-1:0] dec;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    entry_t           slot [DEPTH];
    logic             ready_q;
    logic             valid_q;
    logic [ERR_W-1:0] err_q;

    logic             accept_c;
    logic             pop_c;
    entry_t           in_entry_c;

    function automatic entry_t decode(input logic [3:0] code);
        entry_t e;
        e.err = (code > 4'd9);
        e.dec = e.err ? '0 : (DEC_W'(1) << code);
        return e;
    endfunction

    // Handshakes are qualified by registered flags only, so in_ready never follows out_ready.
    assign accept_c   = bus.in_valid && ready_q && !clr;
    assign pop_c      = valid_q && bus.out_ready;
    assign in_entry_c = decode(bus.bcd);

    // slot[0] is the head and drives the outputs directly; it is zeroed whenever empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            slot[0] <= '0;
            slot[1] <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else if (clr) begin
            state   <= EMPTY;
            slot[0] <= '0;
            slot[1] <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept_c) begin
                        slot[0] <= in_entry_c;
                        state   <= ONE;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                ONE: begin
                    case ({accept_c, pop_c})
                        2'b10: begin
                            slot[1] <= in_entry_c;
                            state   <= FULL;
                            ready_q <= 1'b0;
                        end
                        2'b01: begin
                            slot[0] <= '0;
                            state   <= EMPTY;
                            valid_q <= 1'b0;
                        end
                        2'b11: begin
                            slot[0] <= in_entry_c;
                        end
                        default: begin
                        end
                    endcase
                end
                FULL: begin
                    if (pop_c) begin
                        slot[0] <= slot[1];
                        slot[1] <= '0;
                        state   <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    slot[0] <= '0;
                    slot[1] <= '0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase

            // Saturating count; holds at all-ones rather than wrapping.
            if (accept_c && in_entry_c.err && (err_q != ERR_MAX)) begin
                err_q <= err_q + ERR_W'(1);
            end
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.dec       = slot[0].dec;
    assign bus.out_err   = slot[0].err;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_bcd_to_decimal_decoder.sv
// Directed scoreboard bench for bcd_to_decimal_decoder: a queue model of the
// 2-entry buffer is compared against the outputs every cycle.
module tb_bcd_to_decimal_decoder;
    typedef struct packed {
        logic       err;
        logic [9:0] dec;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clr;
    logic clr2;

    int errors = 0;
    int checks = 0;
    int err_m  = 0;
    exp_t q[$];

    bcd_to_decimal_decoder_if #(.ERR_W(8)) b ();
    bcd_to_decimal_decoder_if #(.ERR_W(2)) b2 ();

    bcd_to_decimal_decoder #(.ERR_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .bus  (b.slave)
    );

    bcd_to_decimal_decoder #(.ERR_W(2)) dut_sat (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr2),
        .bus  (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_decode(input logic [3:0] code);
        exp_t e;
        e.dec = 10'b0;
        e.err = 1'b1;
        if (code < 4'd10) begin
            e.dec[code] = 1'b1;
            e.err       = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t f;
        f = '0;
        if (q.size() > 0) f = q[0];
        chk({tag, ".in_ready"},  32'(b.in_ready),  32'(q.size() < 2));
        chk({tag, ".out_valid"}, 32'(b.out_valid), 32'(q.size() > 0));
        chk({tag, ".dec"},       32'(b.dec),       32'(f.dec));
        chk({tag, ".out_err"},   32'(b.out_err),   32'(f.err));
        chk({tag, ".err_count"}, 32'(b.err_count), 32'(err_m));
    endtask

    // One clock: predict handshakes from the model, update it at the edge, check at the falling edge.
    task automatic cycle(input string tag);
        logic acc;
        logic pop;
        acc = b.in_valid && (q.size() < 2) && !clr;
        pop = (q.size() > 0) && b.out_ready;
        @(posedge clk);
        if (clr) begin
            q.delete();
            err_m = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(model_decode(b.bcd));
                if (b.bcd > 4'd9 && err_m < 255) err_m++;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst_n        = 1'b1;
        clr          = 1'b0;
        clr2         = 1'b0;
        b.in_valid   = 1'b0;
        b.bcd        = 4'd0;
        b.out_ready  = 1'b0;
        b2.in_valid  = 1'b0;
        b2.bcd       = 4'd0;
        b2.out_ready = 1'b0;

        // Async reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs("post_reset");

        // Valid digit sweep, streaming
        b.out_ready = 1'b1;
        b.in_valid  = 1'b1;
        for (int d = 0; d < 10; d++) begin
            b.bcd = 4'(d);
            cycle($sformatf("sweep%0d", d));
        end
        b.in_valid = 1'b0;
        cycle("sweep_drain0");
        cycle("sweep_drain1");

        // Invalid codes
        b.in_valid = 1'b1;
        b.bcd = 4'b1010;
        cycle("inv10");
        b.bcd = 4'b1111;
        cycle("inv15");
        b.in_valid = 1'b0;
        cycle("inv_drain");
        chk("inv_err_count", 32'(b.err_count), 32'd2);

        // Backpressure: 3 and 5 fill the buffer, 7 waits
        b.out_ready = 1'b0;
        b.in_valid  = 1'b1;
        b.bcd = 4'd3;
        cycle("bp3");
        b.bcd = 4'd5;
        cycle("bp5");
        b.bcd = 4'd7;
        cycle("bp7_held");
        chk("bp_in_ready_full", 32'(b.in_ready), 32'd0);
        cycle("bp7_still_held");
        b.out_ready = 1'b1;
        cycle("bp_pop3");
        cycle("bp_pop5_acc7");
        b.in_valid = 1'b0;
        chk("bp_head7", 32'(b.dec), 32'h080);
        cycle("bp_pop7");
        cycle("bp_idle");

        // Simultaneous accept and pop in ONE
        b.out_ready = 1'b0;
        b.in_valid  = 1'b1;
        b.bcd = 4'd1;
        cycle("one_fill1");
        b.out_ready = 1'b1;
        b.bcd = 4'd6;
        cycle("one_swap6");
        chk("one_swap_head6", 32'(b.dec), 32'h040);
        b.in_valid = 1'b0;
        cycle("one_pop6");

        // Synchronous clear drops buffered data, counter and the offered digit
        b.out_ready = 1'b0;
        b.in_valid  = 1'b1;
        b.bcd = 4'd12;
        cycle("clr_fill12");
        b.bcd = 4'd8;
        cycle("clr_fill8");
        clr   = 1'b1;
        b.bcd = 4'd2;
        cycle("clr_apply");
        clr = 1'b0;
        b.in_valid = 1'b0;
        cycle("clr_after");

        // Async reset while FULL, asserted between edges
        b.in_valid = 1'b1;
        b.bcd = 4'd4;
        cycle("rst_fill4");
        b.bcd = 4'd9;
        cycle("rst_fill9");
        b.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        err_m = 0;
        check_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        b.in_valid = 1'b1;
        b.bcd = 4'd2;
        cycle("rst_acc2");
        chk("rst_dec2", 32'(b.dec), 32'h004);
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        cycle("rst_pop2");

        // Saturation on the 2-bit counter instance
        b2.out_ready = 1'b1;
        b2.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b2.bcd = 4'(10 + i);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("sat_count%0d", i), 32'(b2.err_count), 32'((i < 3) ? i + 1 : 3));
        end
        b2.in_valid = 1'b0;
        clr2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr2 = 1'b0;
        chk("sat_clr_count", 32'(b2.err_count), 32'd0);
        chk("sat_clr_valid", 32'(b2.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_to_decimal_decoder.md
BCD_TO_DECIMAL_DECODER -- requirements
Module: bcd_to_decimal_decoder

Interface
REQ-001 Parameter: ERR_W, default 8, width of the invalid-code error counter.
REQ-002 Parameter: DEPTH, fixed at 2, number of output buffer entries; not overridable.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: clr  input  1  synchronous clear of buffer and counter, active-high.
REQ-006 Port: in_valid  input  1  BCD digit on bcd is offered.
REQ-007 Port: in_ready  output  1  block can accept a digit this cycle.
REQ-008 Port: bcd  input  4  BCD code, B3 is MSB.
REQ-009 Port: out_valid  output  1  dec/out_err hold a decoded digit.
REQ-010 Port: out_ready  input  1  consumer takes the current output this cycle.
REQ-011 Port: dec  output  10  one-hot decimal lines; bit n is D(n).
REQ-012 Port: out_err  output  1  current output came from an invalid code (1010-1111).
REQ-013 Port: err_count  output  ERR_W  saturating count of accepted invalid codes.

Function
REQ-014 Input accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-015 Output pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-016 Decode SHALL be: for bcd 0-9, dec = one-hot with bit bcd set and err=0; for bcd 10-15, dec = 10'b0 and err=1.
REQ-017 Decode SHALL be registered into the buffer; a digit accepted at edge N SHALL be visible on dec/out_err with out_valid=1 after edge N when the buffer was empty (latency 1 cycle).
REQ-018 Buffer SHALL be a 2-entry FIFO controlled by states EMPTY, ONE, FULL.
REQ-019 EMPTY: accept -> ONE; otherwise stay.
REQ-020 ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept with pop, or neither -> ONE.
REQ-021 FULL: pop -> ONE; otherwise stay. No accept is possible in FULL.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; it SHALL depend only on state, never combinationally on out_ready.
REQ-023 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-024 Order SHALL be preserved: outputs appear in acceptance order, no loss, no duplication.
REQ-025 dec and out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 When out_valid=0, dec SHALL be 10'b0 and out_err SHALL be 0.
REQ-027 err_count SHALL increment by 1 on each accept with bcd > 9, saturating at 2^ERR_W-1; it SHALL never wrap.
REQ-028 clr=1 SHALL, at the next edge, force state EMPTY, discard buffered entries, and zero err_count; an input offered in that cycle SHALL be dropped.
REQ-029 in_ready SHALL be 1 while clr=1 is applied only if the state permits it; no accept takes effect while clr=1.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk, force state EMPTY, in_ready=1, out_valid=0, dec=10'b0, out_err=0, err_count=0.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered digits; after release, the first accept SHALL behave as from EMPTY.
REQ-032 Release of rst_n SHALL be synchronous to clk by the integrator; no accept SHALL occur on the release edge unless in_valid=1 thereafter.

Verification
REQ-033 Sweep bcd 0-9, one per cycle, out_ready=1 -> dec = 0000000001 .. 1000000000, out_err=0, each 1 cycle after accept, err_count=0.
REQ-034 bcd=1010,1111 with out_ready=1 -> dec=0000000000, out_err=1 each, err_count=2.
REQ-035 out_ready=0, offer 3,5,7 -> 3 and 5 accepted, in_ready=0 after second accept, 7 held off; raise out_ready -> outputs D3,D5,D7 in order, no gap after first pop.
REQ-036 ERR_W=2, offer 5 invalid codes -> err_count saturates at 3; then clr=1 -> err_count=0, out_valid=0.
REQ-037 Buffer FULL with digits 4,9, drop rst_n asynchronously between edges -> out_valid=0, dec=0, in_ready=1 immediately; after release, offer 2 -> dec=0000000100.
REQ-038 State ONE, in_valid=1 and out_ready=1 same edge with bcd=6 -> state stays ONE, next output D6, no loss.
